vec_load_sequencer: RTL and testbench
=====================================

# vec_load_sequencer

Upstream feeder for the vector multiply-accumulate compute stage. It accepts an (a, b) element-pair stream with valid/ready and a last flag and writes each pair into the compute stage's operand memories through its `we`/`index`/`a_data`/`b_data` port. It then presents the element count on `n`, releases the compute stage by dropping `we`, waits for `done`, and reports job completion. It is the only master of the compute stage's load interface.

## Interface
Parameters:
- `DEPTH`, 1024: operand memory depth. Must be a power of two.
- `IDX_W`, 10: index width, equal to log2(`DEPTH`).
- `DATA_W`, 32: element width.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: an input beat is present.
- `in_ready`, output, 1: the block accepts a beat.
- `in_a`, input, `DATA_W`: element of vector a.
- `in_b`, input, `DATA_W`: element of vector b.
- `in_last`, input, 1: final element of the vector.
- `we`, output, 1: load mode for the compute stage. 1 = memories written, compute held. 1→0 = start compute.
- `index`, output, `IDX_W`: write address.
- `a_data`, output, `DATA_W`: write data for memory a.
- `b_data`, output, `DATA_W`: write data for memory b.
- `n`, output, 32: element count of the current job.
- `done`, input, 1: compute-stage completion.
- `busy`, output, 1: a job is between its first accepted beat and `job_done`.
- `job_done`, output, 1: one-cycle pulse when a job completes.
- `trunc_err`, output, 1: the job was cut at `DEPTH` elements. Sticky until the next job's first beat.
- `job_cnt`, output, 16: number of completed jobs. Wraps at 65535→0.

## Operation
State machine `IDLE → LOAD → FLUSH → RUN → FIN → IDLE`.

**IDLE**
- Outputs: `we`=1, `in_ready`=1, `busy`=0.
- First accepted beat (`in_valid && in_ready`):
  - writes element 0;
  - clears `trunc_err`;
  - sets `busy`;
  - goes to LOAD, or to FLUSH if `in_last`=1.

**LOAD**
- Outputs: `we`=1, `in_ready`=1.
- Each accepted beat k registers `index`=k, `a_data`=`in_a`, `b_data`=`in_b`.
- Element counter `cnt` (`IDX_W`+1 bits) increments per beat.

**Termination**
- An accepted beat with `in_last`=1 goes to FLUSH.
- An accepted beat with `cnt`=`DEPTH`-1 and `in_last`=0 also goes to FLUSH and sets `trunc_err`. Beats after it belong to the next job.
- On entry to FLUSH, `n` = `cnt`+1 (zero-extended).

**FLUSH**
- One cycle with `we`=1 and `in_ready`=0, so the last element's write completes.
- Goes to RUN.

**RUN**
- `we`=0, `in_ready`=0.
- `n`, `index`, `a_data` and `b_data` are held stable.
- `done` is ignored in the first RUN cycle, because the compute stage needs one cycle to clear a stale `done`.
- From the second RUN cycle on, `done`=1 goes to FIN.

**FIN**
- One cycle.
- `job_done`=1, `job_cnt` increments, `busy`=0, `we` returns to 1.
- Goes to IDLE. `n` keeps its value until the next FLUSH.

**Other rules**
- An empty vector is impossible, so `n` ≥ 1 for every job.
- Input beats are not accepted in FLUSH, RUN or FIN. Upstream stalls.
- Reset at any point returns to IDLE in the next cycle and aborts any job in progress. No `job_done` is issued for an aborted job.
- Reset values: `we`=1, `in_ready`=0 during the reset cycle (1 after it), `index`=0, `a_data`=0, `b_data`=0, `n`=0, `busy`=0, `job_done`=0, `trunc_err`=0, `job_cnt`=0.

## Timing
- **Write latency:** a beat accepted at cycle t appears on `index`/`a_data`/`b_data` at t+1, with `we`=1.
- **Repeat writes:** `we` stays high through load, so repeated writes of the held address are harmless.
- **Throughput:** 1 beat/cycle in IDLE and LOAD.
- **Start latency:** last beat at cycle t gives FLUSH at t+1 and RUN (`we`=0) at t+2.
- **Completion latency:** `done` sampled high at cycle u (u ≥ RUN entry + 1) gives `job_done` at u+1.
- **Next job:** `in_ready` returns at u+2.
- **Output registers:** all outputs are registered except `in_ready`, which is decoded from state.

## Structure
- A shared package `vec_pkg` holds:
  - the state enum (`S_IDLE`, `S_LOAD`, `S_FLUSH`, `S_RUN`, `S_FIN`);
  - `DEPTH`, `IDX_W` and `DATA_W` defaults, which the compute-stage datapath also uses.
- Single module, no sub-module.
- The new top instantiates `vec_load_sequencer` in front of the compute stage and ties its outputs to the compute stage's `we`, `index`, `a_data`, `b_data` and `n`.

## Test plan
- **3-beat job:**
  - Stimulus: beats (1,2), (3,4), (5,6) with last on the third; `done` asserted 10 cycles into RUN.
  - Required: `index` 0,1,2 on consecutive cycles; `n`=3; `we` falls 2 cycles after the last beat; `job_done` one cycle after `done`; `job_cnt`=1.
- **Single beat with `in_last`:**
  - Stimulus: one beat with `in_last`=1.
  - Required: `n`=1; FLUSH for one cycle; `we`=0 on the next cycle.
- **Truncation:**
  - Stimulus: 1030 beats with no last.
  - Required: `n`=1024, `trunc_err`=1; beat 1025 is stalled until IDLE and then starts job 2 with `index`=0; `trunc_err` clears on that beat.
- **Stale `done`:**
  - Stimulus: `done` held at 1 continuously.
  - Required: RUN lasts exactly 2 cycles; `job_done` pulses once per job.
- **Back-pressure and gaps:**
  - Stimulus: `in_valid` toggling 1,0,1,1; `in_valid`=1 during RUN.
  - Required: no beat is lost or duplicated; `in_ready`=0 during FLUSH, RUN and FIN.
- **Reset mid-job:**
  - Stimulus: `rst` asserted in LOAD after 5 beats, then in RUN.
  - Required: next cycle shows IDLE values (`n`=0, `we`=1, `busy`=0, `job_cnt`=0); no `job_done`.

Source files
------------

// File: rtl/vec_load_sequencer_pkg.sv
// vec_pkg: shared sizes and sequencer state encoding for the vector MAC path
package vec_pkg;
    localparam int DEPTH = 1024;
    localparam int IDX_W = 10;
    localparam int DATA_W = 32;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_FIN} state_t;
endpackage

// File: rtl/vec_load_sequencer_if.sv
// vec_load_sequencer_if: element stream in, compute-stage load port out
interface vec_load_sequencer_if #(
    parameter int IDX_W = vec_pkg::IDX_W,
    parameter int DATA_W = vec_pkg::DATA_W
);
    logic in_valid;
    logic in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic in_last;
    logic we;
    logic [IDX_W-1:0] index;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [31:0] n;
    logic done;
    modport master (
        output in_valid, in_a, in_b, in_last, done,
        input in_ready, we, index, a_data, b_data, n
    );
    modport slave (
        input in_valid, in_a, in_b, in_last, done,
        output in_ready, we, index, a_data, b_data, n
    );
endinterface

// File: rtl/vec_load_sequencer.sv
// vec_load_sequencer: loads an (a,b) stream into the compute stage, then runs it
module vec_load_sequencer #(
    parameter int DEPTH = vec_pkg::DEPTH,
    parameter int IDX_W = vec_pkg::IDX_W,
    parameter int DATA_W = vec_pkg::DATA_W
) (
    input logic clk,
    input logic rst,
    vec_load_sequencer_if.slave bus,
    output logic busy,
    output logic job_done,
    output logic trunc_err,
    output logic [15:0] job_cnt
);
    import vec_pkg::*;
    state_t state, nxt;
    logic [IDX_W:0] cnt, cur;
    logic run_first, accept, term;
    assign bus.in_ready = !rst && (state == S_IDLE || state == S_LOAD);
    assign accept = bus.in_valid && bus.in_ready;
    assign cur = (state == S_IDLE) ? '0 : cnt;
    assign term = bus.in_last || cur == (IDX_W+1)'(DEPTH - 1);
    // next state: stale done is masked during the first RUN cycle
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_LOAD: nxt = accept ? (term ? S_FLUSH : S_LOAD) : state;
            S_FLUSH: nxt = S_RUN;
            S_RUN: nxt = (bus.done && !run_first) ? S_FIN : S_RUN;
            default: nxt = S_IDLE;
        endcase
    end
    // state, write port and job status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= '0;
            run_first <= 1'b0;
            bus.we <= 1'b1;
            bus.index <= '0;
            bus.a_data <= '0;
            bus.b_data <= '0;
            bus.n <= '0;
            busy <= 1'b0;
            job_done <= 1'b0;
            trunc_err <= 1'b0;
            job_cnt <= '0;
        end else begin
            state <= nxt;
            run_first <= state == S_FLUSH;
            bus.we <= nxt != S_RUN;
            busy <= nxt inside {S_LOAD, S_FLUSH, S_RUN};
            job_done <= nxt == S_FIN;
            if (nxt == S_FIN) job_cnt <= job_cnt + 16'd1;
            if (accept) begin
                cnt <= cur + (IDX_W+1)'(1);
                bus.index <= cur[IDX_W-1:0];
                bus.a_data <= bus.in_a;
                bus.b_data <= bus.in_b;
                trunc_err <= term && !bus.in_last;
            end
            if (accept && term) bus.n <= 32'(cur) + 32'd1;
        end
    end
endmodule

// File: tb/tb_vec_load_sequencer.sv
// tb_vec_load_sequencer: directed stimulus with queued expectations checked by a monitor
module tb_vec_load_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, job_done, trunc_err;
    logic [15:0] job_cnt;
    vec_load_sequencer_if vif();
    vec_load_sequencer dut (
        .clk(clk),
        .rst(rst),
        .bus(vif),
        .busy(busy),
        .job_done(job_done),
        .trunc_err(trunc_err),
        .job_cnt(job_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {logic [9:0] idx; logic [31:0] a; logic [31:0] b;} wr_t;
    typedef struct {logic [31:0] n; logic tr; logic [15:0] cnt;} job_t;
    wr_t wq[$];
    job_t jq[$];
    wr_t mw;
    job_t mj;
    int checks = 0;
    int fails = 0;
    int m_idx = 0;
    int m_jobs = 0;
    logic acc_q = 1'b0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic flag(input string name);
        checks++;
        fails++;
        $display("FAIL %s", name);
    endtask
    // monitor: a beat accepted on an edge must show up as a write after it
    always @(posedge clk) acc_q <= vif.in_valid && vif.in_ready;
    always @(negedge clk) begin
        if (acc_q) begin
            if (wq.size() == 0) flag("wr_unexpected");
            else begin
                mw = wq.pop_front();
                chk("wr_index", 64'(vif.index), 64'(mw.idx));
                chk("wr_a", 64'(vif.a_data), 64'(mw.a));
                chk("wr_b", 64'(vif.b_data), 64'(mw.b));
                chk("wr_we", 64'(vif.we), 64'd1);
            end
        end
        if (job_done) begin
            if (jq.size() == 0) flag("job_unexpected");
            else begin
                mj = jq.pop_front();
                chk("job_n", 64'(vif.n), 64'(mj.n));
                chk("job_trunc", 64'(trunc_err), 64'(mj.tr));
                chk("job_cnt", 64'(job_cnt), 64'(mj.cnt));
                chk("job_busy", 64'(busy), 64'd0);
                chk("job_we", 64'(vif.we), 64'd1);
            end
        end
    end
    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last, output int stall);
        int t = 0;
        wr_t w;
        job_t j;
        logic trm;
        vif.in_valid = 1'b1;
        vif.in_a = a;
        vif.in_b = b;
        vif.in_last = last;
        while (!vif.in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        stall = t;
        if (!vif.in_ready) begin
            flag("beat_timeout");
            vif.in_valid = 1'b0;
            return;
        end
        w.idx = 10'(m_idx);
        w.a = a;
        w.b = b;
        wq.push_back(w);
        trm = last || m_idx == 1023;
        if (trm) begin
            j.n = 32'(m_idx + 1);
            j.tr = !last;
            j.cnt = 16'(m_jobs + 1);
            jq.push_back(j);
            m_jobs++;
            m_idx = 0;
        end else m_idx++;
        @(negedge clk);
        vif.in_valid = 1'b0;
    endtask
    task automatic wait_run();
        int t = 0;
        while (vif.we && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (vif.we) flag("run_timeout");
    endtask
    task automatic pulse_done(input int d);
        repeat (d) @(negedge clk);
        vif.done = 1'b1;
        @(negedge clk);
        chk("fin_job_done", 64'(job_done), 64'd1);
        chk("fin_rdy", 64'(vif.in_ready), 64'd0);
        vif.done = 1'b0;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        int s;
        vif.in_valid = 1'b0;
        vif.in_a = '0;
        vif.in_b = '0;
        vif.in_last = 1'b0;
        vif.done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", 64'(vif.in_ready), 64'd0);
        chk("rst_we", 64'(vif.we), 64'd1);
        chk("rst_index", 64'(vif.index), 64'd0);
        chk("rst_a", 64'(vif.a_data), 64'd0);
        chk("rst_b", 64'(vif.b_data), 64'd0);
        chk("rst_n", 64'(vif.n), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_job_done", 64'(job_done), 64'd0);
        chk("rst_trunc", 64'(trunc_err), 64'd0);
        chk("rst_job_cnt", 64'(job_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", 64'(vif.in_ready), 64'd1);
        // three-beat job, done ten cycles into RUN
        beat(32'd1, 32'd2, 1'b0, s);
        chk("load_busy", 64'(busy), 64'd1);
        beat(32'd3, 32'd4, 1'b0, s);
        beat(32'd5, 32'd6, 1'b1, s);
        chk("flush_we", 64'(vif.we), 64'd1);
        chk("flush_rdy", 64'(vif.in_ready), 64'd0);
        chk("flush_n", 64'(vif.n), 64'd3);
        @(negedge clk);
        chk("run_we", 64'(vif.we), 64'd0);
        chk("run_rdy", 64'(vif.in_ready), 64'd0);
        pulse_done(9);
        @(negedge clk);
        chk("idle_rdy2", 64'(vif.in_ready), 64'd1);
        chk("pulse_width", 64'(job_done), 64'd0);
        // single beat with last
        beat(32'd7, 32'd8, 1'b1, s);
        chk("single_flush_we", 64'(vif.we), 64'd1);
        @(negedge clk);
        chk("single_run_we", 64'(vif.we), 64'd0);
        chk("single_n", 64'(vif.n), 64'd1);
        pulse_done(1);
        @(negedge clk);
        // stale done held high: RUN lasts exactly two cycles
        vif.done = 1'b1;
        beat(32'd9, 32'd10, 1'b1, s);
        chk("stale_flush_we", 64'(vif.we), 64'd1);
        @(negedge clk);
        chk("stale_run1_we", 64'(vif.we), 64'd0);
        @(negedge clk);
        chk("stale_run2_we", 64'(vif.we), 64'd0);
        chk("stale_run2_done", 64'(job_done), 64'd0);
        @(negedge clk);
        chk("stale_fin", 64'(job_done), 64'd1);
        @(negedge clk);
        chk("stale_once", 64'(job_done), 64'd0);
        chk("stale_idle_rdy", 64'(vif.in_ready), 64'd1);
        beat(32'd11, 32'd12, 1'b0, s);
        beat(32'd13, 32'd14, 1'b1, s);
        repeat (5) @(negedge clk);
        // gaps and a beat presented during FLUSH/RUN/FIN
        beat(32'd20, 32'd21, 1'b0, s);
        @(negedge clk);
        beat(32'd22, 32'd23, 1'b0, s);
        beat(32'd24, 32'd25, 1'b1, s);
        beat(32'd26, 32'd27, 1'b1, s);
        chk("stall_cycles", 64'(s), 64'd4);
        repeat (5) @(negedge clk);
        // truncation at DEPTH elements
        for (int i = 0; i < 1030; i++) begin
            beat(32'(i) + 32'h1000, ~32'(i), i == 1029, s);
            if (i == 1023) begin
                chk("trunc_set", 64'(trunc_err), 64'd1);
                chk("trunc_n", 64'(vif.n), 64'd1024);
            end
            if (i == 1024) begin
                chk("trunc_stall", 64'(s), 64'd4);
                chk("trunc_clr", 64'(trunc_err), 64'd0);
            end
        end
        repeat (5) @(negedge clk);
        vif.done = 1'b0;
        // reset during LOAD
        for (int i = 0; i < 5; i++) beat(32'(100 + i), 32'(200 + i), 1'b0, s);
        rst = 1'b1;
        @(negedge clk);
        chk("rl_n", 64'(vif.n), 64'd0);
        chk("rl_we", 64'(vif.we), 64'd1);
        chk("rl_busy", 64'(busy), 64'd0);
        chk("rl_job_cnt", 64'(job_cnt), 64'd0);
        chk("rl_index", 64'(vif.index), 64'd0);
        m_idx = 0;
        m_jobs = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("rl_rdy", 64'(vif.in_ready), 64'd1);
        // reset during RUN aborts without job_done
        beat(32'd1, 32'd1, 1'b0, s);
        beat(32'd2, 32'd2, 1'b1, s);
        wait_run();
        rst = 1'b1;
        jq.delete();
        m_idx = 0;
        m_jobs = 0;
        @(negedge clk);
        chk("rr_we", 64'(vif.we), 64'd1);
        chk("rr_n", 64'(vif.n), 64'd0);
        chk("rr_busy", 64'(busy), 64'd0);
        chk("rr_job_done", 64'(job_done), 64'd0);
        rst = 1'b0;
        vif.done = 1'b1;
        repeat (3) @(negedge clk);
        chk("rr_no_done", 64'(job_done), 64'd0);
        vif.done = 1'b0;
        beat(32'd5, 32'd6, 1'b1, s);
        wait_run();
        pulse_done(2);
        repeat (3) @(negedge clk);
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("jq_empty", 64'(jq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
